// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: opcode/funct, ALU and load/store size codes, FSM states and mux selects
package mc_controller_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LWL = 6'h22, OP_LW = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SWL = 6'h2a, OP_SW = 6'h2b, OP_SWR = 6'h2e;
  localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_JALR = 6'h09, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
  localparam logic [7:0] ALU_NOP = 8'h00, ALU_ADD = 8'h01, ALU_SUB = 8'h02, ALU_OR = 8'h03;
  localparam logic [7:0] ALU_SLL = 8'h04, ALU_EQ = 8'h05;
  localparam logic [2:0] SL_WORD = 3'd0, SL_HALF = 3'd1, SL_BYTE = 3'd2, SL_HALFU = 3'd3;
  localparam logic [2:0] SL_BYTEU = 3'd4, SL_LEFT = 3'd5, SL_RIGHT = 3'd6;
  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
  localparam logic [1:0] A3_RD = 2'd0, A3_RT = 2'd1, A3_RA = 2'd2;
  localparam logic [1:0] DTR_ALU = 2'd0, DTR_MDR = 2'd1, DTR_PC = 2'd2;
  localparam logic [1:0] ALUB_RT = 2'd0, ALUB_4 = 2'd1, ALUB_IMM = 2'd2, ALUB_IMM4 = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
  typedef enum logic [2:0] {CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP} iclass_t;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP
  } state_t;
  function automatic logic [2:0] sl_mode(input logic [5:0] op);
    case (op)
      OP_LB, OP_SB: sl_mode = SL_BYTE;
      OP_LBU: sl_mode = SL_BYTEU;
      OP_LH, OP_SH: sl_mode = SL_HALF;
      OP_LHU: sl_mode = SL_HALFU;
      OP_LWL, OP_SWL: sl_mode = SL_LEFT;
      OP_LWR, OP_SWR: sl_mode = SL_RIGHT;
      default: sl_mode = SL_WORD;
    endcase
  endfunction
endpackage

// File: rtl/mc_controller_decode.sv
// mc_decode: opcode/funct to instruction class and decode fields
module mc_decode
  import mc_controller_pkg::*;
#(
  parameter int PARTIAL_LS = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] cls,
  output logic [7:0] alu,
  output logic [1:0] ext,
  output logic [2:0] sl,
  output logic [1:0] a3,
  output logic       link,
  output logic       legal
);
  always_comb begin
    cls = CL_ALU_R;
    alu = ALU_ADD;
    ext = EXT_ZERO;
    sl = SL_WORD;
    a3 = A3_RD;
    link = 1'b0;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        alu = funct == FN_SUBU ? ALU_SUB : funct == FN_SLL ? ALU_SLL : ALU_ADD;
        cls = (funct == FN_JR || funct == FN_JALR) ? CL_JUMP : CL_ALU_R;
        link = funct == FN_JALR;
        legal = funct inside {FN_ADDU, FN_SUBU, FN_SLL, FN_JR, FN_JALR};
      end
      OP_ORI, OP_LUI: begin
        cls = CL_ALU_I;
        alu = ALU_OR;
        ext = opcode == OP_LUI ? EXT_LUI : EXT_ZERO;
        a3 = A3_RT;
      end
      OP_BEQ: begin
        cls = CL_BRANCH;
        alu = ALU_EQ;
      end
      OP_J: cls = CL_JUMP;
      OP_JAL: begin
        cls = CL_JUMP;
        link = 1'b1;
        a3 = A3_RA;
      end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        cls = CL_LOAD;
        a3 = A3_RT;
        ext = EXT_SIGN;
        sl = sl_mode(opcode);
        legal = PARTIAL_LS != 0 || opcode == OP_LW;
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
        cls = CL_STORE;
        ext = EXT_SIGN;
        sl = sl_mode(opcode);
        legal = PARTIAL_LS != 0 || opcode == OP_SW;
      end
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM with memory handshake and retire counter
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int ALU_W = 8,
  parameter int SL_W = 3,
  parameter int PARTIAL_LS = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_eq,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_a3_sel,
  output logic [1:0]       data_to_reg,
  output logic             alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       ext_ctrl,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [SL_W-1:0]  sl_ctrl,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  state_t state, nxt;
  logic sync1, run;
  logic [2:0] cls, sl_d, sl_op;
  logic [7:0] alu_d, alu_op;
  logic [1:0] ext_d, a3_d;
  logic link, legal;
  mc_decode #(.PARTIAL_LS(PARTIAL_LS)) u_dec (
    .opcode(opcode), .funct(funct), .cls(cls), .alu(alu_d), .ext(ext_d),
    .sl(sl_d), .a3(a3_d), .link(link), .legal(legal)
  );
  assign alu_ctrl = ALU_W'(alu_op);
  assign sl_ctrl = SL_W'(sl_op);
  // run rises two clocks after rst_n release; until then every output stays 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      run <= 1'b0;
      state <= S_FETCH;
      retired <= '0;
    end else begin
      sync1 <= 1'b1;
      run <= sync1;
      state <= nxt;
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end
  always_comb begin
    nxt = state;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = PC_PLUS4;
    reg_we = 1'b0;
    reg_a3_sel = A3_RD;
    data_to_reg = DTR_ALU;
    alu_a_sel = 1'b0;
    alu_b_sel = ALUB_RT;
    ext_ctrl = EXT_ZERO;
    alu_op = ALU_NOP;
    sl_op = SL_WORD;
    instr_done = 1'b0;
    illegal = 1'b0;
    if (run) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alu_b_sel = ALUB_4;
          alu_op = ALU_ADD;
          ir_we = mem_ready;
          pc_we = mem_ready;
          nxt = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_b_sel = ALUB_IMM4;
          ext_ctrl = EXT_SIGN;
          alu_op = ALU_ADD;
          illegal = !legal;
          nxt = !legal ? S_FETCH : cls == CL_ALU_R ? S_EXEC_R : cls == CL_ALU_I ? S_EXEC_I :
                cls == CL_BRANCH ? S_BRANCH : cls == CL_JUMP ? S_JUMP : S_MEM_ADDR;
        end
        S_EXEC_R: begin
          alu_a_sel = 1'b1;
          alu_op = alu_d;
          nxt = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_a_sel = 1'b1;
          alu_b_sel = ALUB_IMM;
          ext_ctrl = ext_d;
          alu_op = alu_d;
          nxt = S_WB_ALU;
        end
        S_MEM_ADDR: begin
          alu_a_sel = 1'b1;
          alu_b_sel = ALUB_IMM;
          ext_ctrl = EXT_SIGN;
          alu_op = ALU_ADD;
          nxt = cls == CL_LOAD ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD, S_MEM_WR: begin
          mem_req = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we = state == S_MEM_WR;
          sl_op = sl_d;
          instr_done = mem_ready && state == S_MEM_WR;
          nxt = !mem_ready ? state : state == S_MEM_RD ? S_WB_MEM : S_FETCH;
        end
        S_WB_ALU, S_WB_MEM: begin
          reg_we = 1'b1;
          reg_a3_sel = state == S_WB_MEM ? A3_RT : a3_d;
          data_to_reg = state == S_WB_MEM ? DTR_MDR : DTR_ALU;
          sl_op = state == S_WB_MEM ? sl_d : SL_WORD;
          instr_done = 1'b1;
          nxt = S_FETCH;
        end
        S_BRANCH: begin
          alu_a_sel = 1'b1;
          alu_op = ALU_EQ;
          pc_we = alu_eq;
          pc_src = PC_BRANCH;
          instr_done = 1'b1;
          nxt = S_FETCH;
        end
        S_JUMP: begin
          pc_we = 1'b1;
          pc_src = opcode == OP_RTYPE ? PC_RS : PC_JUMP;
          reg_we = link;
          reg_a3_sel = a3_d;
          data_to_reg = link ? DTR_PC : DTR_ALU;
          instr_done = 1'b1;
          nxt = S_FETCH;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven and randomized checks of mc_controller against an instruction-level model
module tb_mc_controller;
  import mc_controller_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, alu_eq = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, alu_a_sel, instr_done, illegal;
  logic [1:0] pc_src, reg_a3_sel, data_to_reg, alu_b_sel, ext_ctrl;
  logic [7:0] alu_ctrl;
  logic [2:0] sl_ctrl;
  logic [31:0] retired;
  logic mem_req0, mem_we0, mem_addr_sel0, ir_we0, pc_we0, reg_we0, alu_a_sel0, instr_done0, illegal0;
  logic [1:0] pc_src0, reg_a3_sel0, data_to_reg0, alu_b_sel0, ext_ctrl0;
  logic [7:0] alu_ctrl0;
  logic [2:0] sl_ctrl0;
  logic [31:0] retired0;
  int errors = 0, checks = 0;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_eq(alu_eq), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .reg_a3_sel(reg_a3_sel), .data_to_reg(data_to_reg),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .ext_ctrl(ext_ctrl), .alu_ctrl(alu_ctrl),
    .sl_ctrl(sl_ctrl), .instr_done(instr_done), .illegal(illegal), .retired(retired)
  );
  mc_controller #(.PARTIAL_LS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_eq(alu_eq), .mem_ready(mem_ready),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr_sel(mem_addr_sel0), .ir_we(ir_we0), .pc_we(pc_we0),
    .pc_src(pc_src0), .reg_we(reg_we0), .reg_a3_sel(reg_a3_sel0), .data_to_reg(data_to_reg0),
    .alu_a_sel(alu_a_sel0), .alu_b_sel(alu_b_sel0), .ext_ctrl(ext_ctrl0), .alu_ctrl(alu_ctrl0),
    .sl_ctrl(sl_ctrl0), .instr_done(instr_done0), .illegal(illegal0), .retired(retired0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc, nreq, nwe, nir, nreg, a3, dtr, npc, psrc, sl, slbad, alu, ext, nill, ndone, tmo;
  } obs_t;
  typedef struct {
    logic [5:0] op, fn;
    bit eq;
    int fw, mw, cyc, nreg, a3, dtr, npc, psrc, sl, ret;
  } vec_t;

  localparam logic [11:0] POOL [25] = '{
    {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h00}, {6'h00, 6'h08}, {6'h00, 6'h09},
    {6'h00, 6'h2a}, {6'h0d, 6'h00}, {6'h0f, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00},
    {6'h20, 6'h00}, {6'h21, 6'h00}, {6'h22, 6'h00}, {6'h24, 6'h00}, {6'h25, 6'h00},
    {6'h26, 6'h00}, {6'h28, 6'h00}, {6'h29, 6'h00}, {6'h2a, 6'h00}, {6'h2e, 6'h00},
    {6'h04, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h3f, 6'h00}, {6'h0c, 6'h00}
  };

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level expectations from the class of the instruction and the memory wait counts
  function automatic obs_t model(input logic [5:0] op, fn, input bit eq, input int fw, mw);
    obs_t e;
    bit r, alur, alui, ld, st, br, jr, jp, lnk, ok;
    e = '{default: 0};
    r = op == 6'h00;
    alur = r && (fn == 6'h21 || fn == 6'h23 || fn == 6'h00);
    jr = r && (fn == 6'h08 || fn == 6'h09);
    alui = op == 6'h0d || op == 6'h0f;
    ld = op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
    st = op inside {6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e};
    br = op == 6'h04;
    jp = jr || op == 6'h02 || op == 6'h03;
    lnk = (r && fn == 6'h09) || op == 6'h03;
    ok = alur || alui || ld || st || br || jp;
    e.cyc = 2 + fw + (!ok ? 0 : (alur || alui) ? 2 : ld ? 3 + mw : st ? 2 + mw : 1);
    e.nreq = fw + 1 + ((ld || st) ? mw + 1 : 0);
    e.nwe = st ? mw + 1 : 0;
    e.nir = 1;
    e.nreg = (alur || alui || ld || lnk) ? 1 : 0;
    e.a3 = (alui || ld) ? 1 : op == 6'h03 ? 2 : 0;
    e.dtr = ld ? 1 : lnk ? 2 : 0;
    e.npc = (jp || (br && eq)) ? 2 : 1;
    e.psrc = jp ? (jr ? 3 : 2) : (br && eq) ? 1 : 0;
    e.sl = (op == 6'h20 || op == 6'h28) ? 2 : op == 6'h24 ? 4 : (op == 6'h21 || op == 6'h29) ? 1 :
           op == 6'h25 ? 3 : (op == 6'h22 || op == 6'h2a) ? 5 : (op == 6'h26 || op == 6'h2e) ? 6 : 0;
    e.alu = alur ? (fn == 6'h21 ? ALU_ADD : fn == 6'h23 ? ALU_SUB : ALU_SLL) : alui ? ALU_OR :
            (ld || st) ? ALU_ADD : br ? ALU_EQ : 255;
    e.ext = op == 6'h0f ? 2 : (ld || st) ? 1 : (alur || alui || br) ? 0 : 3;
    e.nill = ok ? 0 : 1;
    e.ndone = ok ? 1 : 0;
    return e;
  endfunction

  // Runs one instruction from FETCH; memory answers after fw (fetch) or mw (data) wait cycles
  task automatic run(input logic [5:0] op, fn, input bit eq, input int fw, mw, output obs_t o);
    int wcnt;
    bit fin, slseen, aseen;
    o = '{default: 0};
    o.alu = 255;
    o.ext = 3;
    wcnt = 0;
    fin = 0;
    slseen = 0;
    aseen = 0;
    opcode = op;
    funct = fn;
    alu_eq = eq;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (mem_req) begin
        mem_ready = wcnt == (mem_addr_sel ? mw : fw);
        wcnt = mem_ready ? 0 : wcnt + 1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        wcnt = 0;
      end
      #1;
      o.cyc++;
      o.nreq += int'(mem_req);
      o.nwe += int'(mem_we);
      o.nir += int'(ir_we);
      if (reg_we) begin
        o.nreg++;
        o.a3 = reg_a3_sel;
        o.dtr = data_to_reg;
      end
      if (pc_we) begin
        o.npc++;
        if (!ir_we) o.psrc = pc_src;
      end
      if (mem_req && mem_addr_sel) begin
        if (slseen && sl_ctrl != 3'(o.sl)) o.slbad = 1;
        o.sl = sl_ctrl;
        slseen = 1;
      end
      if (alu_a_sel && !aseen) begin
        o.alu = alu_ctrl;
        o.ext = ext_ctrl;
        aseen = 1;
      end
      o.nill += int'(illegal);
      o.ndone += int'(instr_done);
      fin = instr_done || illegal;
    end
    o.tmo = fin ? 0 : 1;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string t, input obs_t o, input obs_t e);
    chk({t, ".cycles"}, o.cyc, e.cyc);
    chk({t, ".mem_req_cycles"}, o.nreq, e.nreq);
    chk({t, ".mem_we_cycles"}, o.nwe, e.nwe);
    chk({t, ".ir_we"}, o.nir, e.nir);
    chk({t, ".reg_we"}, o.nreg, e.nreg);
    chk({t, ".a3_sel"}, o.a3, e.a3);
    chk({t, ".data_to_reg"}, o.dtr, e.dtr);
    chk({t, ".pc_we"}, o.npc, e.npc);
    chk({t, ".pc_src"}, o.psrc, e.psrc);
    chk({t, ".sl_ctrl"}, o.sl, e.sl);
    chk({t, ".sl_stable"}, o.slbad, 0);
    chk({t, ".alu_ctrl"}, o.alu, e.alu);
    chk({t, ".ext_ctrl"}, o.ext, e.ext);
    chk({t, ".illegal"}, o.nill, e.nill);
    chk({t, ".instr_done"}, o.ndone, e.ndone);
    chk({t, ".timeout"}, o.tmo, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (mem_req) break;
    end
    chk("reset_release_fetch", int'(mem_req), 1);
  endtask

  initial begin
    vec_t tab[12];
    obs_t o;
    int exp_ret, n, nreq0, nreg0, nd0, k;
    bit got, seen;
    logic [5:0] op, fn;
    tab[0]  = '{6'h00, 6'h21, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 1};
    tab[1]  = '{6'h23, 6'h00, 0, 3, 3, 11, 1, 1, 1, 1, 0, 0, 1};
    tab[2]  = '{6'h04, 6'h00, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 1};
    tab[3]  = '{6'h04, 6'h00, 1, 0, 0, 3, 0, 0, 0, 2, 1, 0, 1};
    tab[4]  = '{6'h03, 6'h00, 0, 0, 0, 3, 1, 2, 2, 2, 2, 0, 1};
    tab[5]  = '{6'h00, 6'h09, 0, 0, 0, 3, 1, 0, 2, 2, 3, 0, 1};
    tab[6]  = '{6'h2b, 6'h00, 0, 1, 2, 7, 0, 0, 0, 1, 0, 0, 1};
    tab[7]  = '{6'h0f, 6'h00, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 1};
    tab[8]  = '{6'h3f, 6'h00, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0};
    tab[9]  = '{6'h20, 6'h00, 0, 2, 1, 8, 1, 1, 1, 1, 0, 2, 1};
    tab[10] = '{6'h00, 6'h08, 0, 1, 0, 4, 0, 0, 0, 2, 3, 0, 1};
    tab[11] = '{6'h29, 6'h00, 0, 0, 0, 4, 0, 0, 0, 1, 0, 1, 1};
    exp_ret = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs_zero", int'(|{mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we,
        reg_a3_sel, data_to_reg, alu_a_sel, alu_b_sel, ext_ctrl, alu_ctrl, sl_ctrl, instr_done, illegal}), 0);
    chk("reset_retired", int'(retired), 0);
    do_reset();
    chk("reset_fetch_addr_sel", int'(mem_addr_sel), 0);
    chk("reset_fetch_alu_b", int'(alu_b_sel), 1);
    for (int i = 0; i < 12; i++) begin
      run(tab[i].op, tab[i].fn, tab[i].eq, tab[i].fw, tab[i].mw, o);
      exp_ret += tab[i].ret;
      chk($sformatf("vec%0d.cycles", i), o.cyc, tab[i].cyc);
      chk($sformatf("vec%0d.reg_we", i), o.nreg, tab[i].nreg);
      chk($sformatf("vec%0d.a3_sel", i), o.a3, tab[i].a3);
      chk($sformatf("vec%0d.data_to_reg", i), o.dtr, tab[i].dtr);
      chk($sformatf("vec%0d.pc_we", i), o.npc, tab[i].npc);
      chk($sformatf("vec%0d.pc_src", i), o.psrc, tab[i].psrc);
      chk($sformatf("vec%0d.sl_ctrl", i), o.sl, tab[i].sl);
      chk($sformatf("vec%0d.retired", i), int'(retired), exp_ret);
      cmp($sformatf("vec%0d", i), o, model(tab[i].op, tab[i].fn, tab[i].eq, tab[i].fw, tab[i].mw));
    end
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 24));
      op = POOL[k][11:6];
      fn = op == 6'h00 ? POOL[k][5:0] : 6'($urandom);
      got = 1'($urandom_range(0, 1));
      n = int'($urandom_range(0, 3));
      nreq0 = int'($urandom_range(0, 3));
      run(op, fn, got, n, nreq0, o);
      cmp($sformatf("rnd%0d_op%0h_fn%0h", i, op, fn), o, model(op, fn, got, n, nreq0));
      exp_ret += model(op, fn, got, n, nreq0).ndone;
      chk($sformatf("rnd%0d.retired", i), int'(retired), exp_ret);
    end
    // Partial loads illegal when PARTIAL_LS = 0
    do_reset();
    opcode = OP_LB;
    funct = 6'h00;
    n = 0;
    got = 0;
    nreq0 = 0;
    nreg0 = 0;
    nd0 = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      mem_ready = mem_req0;
      #1;
      n++;
      nreq0 += int'(mem_req0);
      nreg0 += int'(reg_we0);
      nd0 += int'(instr_done0);
      got = illegal0;
    end
    chk("nopartial.illegal_seen", int'(got), 1);
    chk("nopartial.illegal_cycle", n, 2);
    chk("nopartial.mem_req_cycles", nreq0, 1);
    chk("nopartial.reg_we", nreg0, 0);
    chk("nopartial.instr_done", nd0, 0);
    chk("nopartial.no_writes", int'({mem_we0, ir_we0, pc_we0, mem_addr_sel0, pc_src0, reg_a3_sel0,
        data_to_reg0, alu_a_sel0}), 0);
    chk("nopartial.decode_alu_b", int'(alu_b_sel0), 3);
    chk("nopartial.decode_misc", int'({ext_ctrl0, alu_ctrl0, sl_ctrl0}), int'({2'd1, ALU_ADD, 3'd0}));
    @(posedge clk);
    #1;
    chk("nopartial.retired", int'(retired0), 0);
    chk("nopartial.back_to_fetch", int'(mem_req0 && !mem_addr_sel0), 1);
    // Reset during a store's memory wait
    do_reset();
    run(OP_RTYPE, FN_ADDU, 0, 0, 0, o);
    chk("prewr.retired", int'(retired), 1);
    opcode = OP_SW;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      mem_ready = mem_req && !mem_addr_sel;
      #1;
      seen = mem_we;
    end
    chk("midwr.reached", int'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midwr.req_drops", int'(mem_req), 0);
    chk("midwr.we_drops", int'(mem_we), 0);
    chk("midwr.retired_cleared", int'(retired), 0);
    do_reset();
    chk("midwr.fetch_addr_sel", int'(mem_addr_sel), 0);
    chk("midwr.fetch_not_write", int'(mem_we), 0);
    chk("midwr.retired_after", int'(retired), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM for the MIPS datapath, replacing the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK using a ready/request handshake to a shared instruction/data memory.
- Emits per-state datapath enables plus the same decode fields (EXT, ALU, SL controls).
- Adds an optional partial-word load/store subset and a retired-instruction counter.

Parameters:
- ALU_W, 8, width of alu_ctrl; encodings from shared package.
- SL_W, 3, width of sl_ctrl; encodings from shared package.
- PARTIAL_LS, 1, 1 = lh/lb/lhu/lbu/lwl/lwr/sh/sb/swl/swr legal; 0 = those opcodes are illegal.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- alu_eq  in  1  ALU equality result, sampled in BRANCH
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write request (valid with mem_req)
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut
- ir_we  out  1  load IR
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump index, 3 = rs
- reg_we  out  1  register file write
- reg_a3_sel  out  2  0 = rd, 1 = rt, 2 = $31
- data_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
- alu_a_sel  out  1  0 = PC, 1 = rs
- alu_b_sel  out  2  0 = rt, 1 = 4, 2 = ext imm, 3 = ext imm << 2
- ext_ctrl  out  2  0 = zero-ext, 1 = sign-ext, 2 = lui shift
- alu_ctrl  out  ALU_W  ALU operation
- sl_ctrl  out  SL_W  load/store size mode
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on undecodable instruction
- retired  out  CNT_W  retired instruction count

Behaviour:
- Reset: state = FETCH; all outputs 0 (including mem_req and retired). Asynchronous assertion; release is synchronised to clk. Reset mid-request drops mem_req immediately.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP.
- FETCH: mem_req = 1, mem_addr_sel = 0, alu_a_sel = 0, alu_b_sel = 1, alu_ctrl = add. Hold while mem_ready = 0. On mem_ready: ir_we = pc_we = 1, pc_src = 0, go to DECODE.
- DECODE: alu_a_sel = 0, alu_b_sel = 3 (branch target precompute). Next state by opcode/funct:
  - addu/subu/sll -> EXEC_R
  - ori/lui -> EXEC_I
  - loads/stores -> MEM_ADDR
  - beq -> BRANCH
  - j/jal/jr/jalr -> JUMP
  - otherwise: illegal = 1 -> FETCH, no writes.
- EXEC_R -> WB_ALU with reg_a3_sel = 0. EXEC_I -> WB_ALU with reg_a3_sel = 1, ext = 0 (ori) or 2 (lui).
- MEM_ADDR: alu_b_sel = 2, ext = 1, add; then MEM_RD (load) or MEM_WR (store).
- MEM_RD/MEM_WR: mem_req = 1, mem_addr_sel = 1, mem_we = 1 only in MEM_WR; sl_ctrl stable for the whole request. Wait for mem_ready.
  - MEM_RD -> WB_MEM.
  - MEM_WR retires -> FETCH.
- WB_ALU/WB_MEM: reg_we = 1 for exactly one cycle; retire -> FETCH.
- BRANCH: alu_ctrl = eq, alu_b_sel = 0. pc_we = alu_eq, pc_src = 1. Retire -> FETCH.
- JUMP: one cycle; pc_we = 1.
  - pc_src = 2 for j/jal, 3 for jr/jalr.
  - reg_we = 1, data_to_reg = 2 for jal (a3 = 2) and jalr (a3 = 0).
  - Retire -> FETCH.
- Retire: instr_done = 1 in the last cycle of the instruction; retired += 1 (wraps modulo 2^CNT_W). Illegal instructions do not count.
- mem_ready outside a request is ignored. mem_ready asserted in the first cycle of a request advances the FSM next cycle (minimum FETCH = 1 cycle).
- Cycle counts with zero wait:
  - R/I-type: 4
  - load: 5
  - store: 4
  - beq: 3
  - jump: 3

Decomposition:
- Shared package (define file): opcode/funct constants, ALU op codes, SL mode codes, state encoding, mux-select constants.
- Natural sub-module: mc_decode — combinational opcode/funct -> {class, alu_ctrl, ext_ctrl, sl_ctrl, a3 sel, legal}, honouring PARTIAL_LS.

Test Plan:
- addu $3,$1,$2 with mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_we pulse on cycle 4 with a3_sel = 0; retired = 1.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> mem_req held high 4 cycles each time; reg_we on cycle 11; sl_ctrl = word throughout MEM_RD.
- beq with alu_eq = 0, then alu_eq = 1 -> pc_we 0 then 1 in BRANCH with pc_src = 1; each takes 3 cycles.
- jal then jalr -> reg_we with a3_sel = 2 then 0, data_to_reg = 2, pc_src = 2 then 3.
- PARTIAL_LS = 0, opcode lb -> illegal pulse in DECODE, no reg_we/mem_req; retired unchanged.
- rst_n low during MEM_WR wait -> mem_req drops same cycle; after release FSM in FETCH; retired = 0.
